// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array tile sequencer and the
// instruction decoder that feeds it.
//   - state_t  : tile sequencer FSM encoding
//   - SA_*     : default array size, address width, row-count width, MMU latency
//   - sa_cmd_t : matmul-tile command field layout at the default widths
package sa_pkg;

  localparam int SA_ARRAY_N = 16;
  localparam int SA_ADDR_W  = 8;
  localparam int SA_LEN_W   = 8;
  localparam int SA_MMU_LAT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_WLATCH,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [SA_ADDR_W-1:0] ub_base;
    logic [SA_ADDR_W-1:0] wb_base;
    logic [SA_ADDR_W-1:0] acc_base;
    logic [SA_LEN_W-1:0]  rows;
    logic                 accumulate;
  } sa_cmd_t;

endpackage

// File: rtl/sa_delay_line.sv
// Fixed-depth valid/data shift register.
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   din        : WIDTH-bit input sampled every cycle
//   dout       : din delayed by DEPTH cycles
module sa_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_p [DEPTH];

  // Stage 0 captures din; stage i captures stage i-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile-level sequencer for the systolic-array datapath. Accepts one matmul
// tile command, then drives weight loading, the MMU weight latch, activation
// row streaming and delayed accumulator writes, pulsing done at the end.
//   cmd_*                : command handshake and fields (accepted in IDLE only)
//   busy, done, err      : status; err pulses for a zero-row command
//   wb_re/wb_addr        : weight buffer read
//   weight_fifo_en       : weight FIFO shift (wb_re + 1 cycle)
//   mmu_load_weight      : MMU weight latch strobe
//   ub_re/ub_addr        : unified buffer read
//   data_fifo_en, mm_en  : data FIFO shift / MMU compute (ub_re + 1 cycle)
//   acc_we/acc_addr      : accumulator write (mm_en + MMU_LAT cycles)
//   acc_en               : accumulate-mode qualifier for acc_we
module sa_tile_sequencer
  import sa_pkg::*;
#(
  parameter int ARRAY_N = SA_ARRAY_N,
  parameter int ADDR_W  = SA_ADDR_W,
  parameter int LEN_W   = SA_LEN_W,
  parameter int MMU_LAT = SA_MMU_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_ub_base,
  input  logic [ADDR_W-1:0] cmd_wb_base,
  input  logic [ADDR_W-1:0] cmd_acc_base,
  input  logic [LEN_W-1:0]  cmd_rows,
  input  logic              cmd_accumulate,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wb_re,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              weight_fifo_en,
  output logic              mmu_load_weight,
  output logic              ub_re,
  output logic [ADDR_W-1:0] ub_addr,
  output logic              data_fifo_en,
  output logic              mm_en,
  output logic              acc_we,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              acc_en
);

  localparam int WCNT_W = $clog2(ARRAY_N + 1);

  state_t state, state_nxt;

  logic [WCNT_W-1:0] wcnt;
  logic [LEN_W-1:0]  rcnt;
  logic [LEN_W-1:0]  acnt;
  logic              err_q;

  logic [ADDR_W-1:0] ub_base_q;
  logic [ADDR_W-1:0] wb_base_q;
  logic [ADDR_W-1:0] acc_base_q;
  logic [LEN_W-1:0]  rows_q;
  logic              accumulate_q;

  logic              accept;
  logic [LEN_W-1:0]  rows_m1;
  logic              ub_dly;

  assign accept  = cmd_valid && cmd_ready;
  assign rows_m1 = rows_q - LEN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      rcnt  <= '0;
      acnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= accept && (cmd_rows == '0);
      wcnt  <= (state == ST_WLOAD)  ? wcnt + WCNT_W'(1) : '0;
      rcnt  <= (state == ST_STREAM) ? rcnt + LEN_W'(1)  : '0;
      if (state == ST_IDLE)
        acnt <= '0;
      else if (acc_we)
        acnt <= acnt + LEN_W'(1);
    end
  end

  // Command fields are latched at acceptance only; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      ub_base_q    <= cmd_ub_base;
      wb_base_q    <= cmd_wb_base;
      acc_base_q   <= cmd_acc_base;
      rows_q       <= cmd_rows;
      accumulate_q <= cmd_accumulate;
    end
  end

  // WLOAD spans ARRAY_N+1 cycles: ARRAY_N reads plus one cycle for the last
  // BRAM word to reach the weight FIFO before the MMU latches the weights.
  always_comb begin
    state_nxt       = state;
    cmd_ready       = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    wb_re           = 1'b0;
    mmu_load_weight = 1'b0;
    ub_re           = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_rows != '0)) state_nxt = ST_WLOAD;
      end
      ST_WLOAD: begin
        busy  = 1'b1;
        wb_re = (wcnt < WCNT_W'(ARRAY_N));
        if (wcnt == WCNT_W'(ARRAY_N)) state_nxt = ST_WLATCH;
      end
      ST_WLATCH: begin
        busy            = 1'b1;
        mmu_load_weight = 1'b1;
        state_nxt       = ST_STREAM;
      end
      ST_STREAM: begin
        busy  = 1'b1;
        ub_re = 1'b1;
        if (rcnt == rows_m1) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // The final write drains the last valid bit from the result pipe.
        if (acc_we && (acnt == rows_m1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign err      = err_q;
  assign wb_addr  = wb_re  ? wb_base_q  + ADDR_W'(wcnt) : '0;
  assign ub_addr  = ub_re  ? ub_base_q  + ADDR_W'(rcnt) : '0;
  assign acc_addr = acc_we ? acc_base_q + ADDR_W'(acnt) : '0;
  assign acc_en   = acc_we && accumulate_q;

  // BRAM read latency into the weight FIFO
  sa_delay_line #(.DEPTH(1), .WIDTH(1)) u_wb_dly (
    .clk   (clk),
    .reset (reset),
    .din   (wb_re),
    .dout  (weight_fifo_en)
  );

  // BRAM read latency into the data FIFO / MMU
  sa_delay_line #(.DEPTH(1), .WIDTH(1)) u_ub_dly (
    .clk   (clk),
    .reset (reset),
    .din   (ub_re),
    .dout  (ub_dly)
  );

  assign data_fifo_en = ub_dly;
  assign mm_en        = ub_dly;

  // MMU result latency: each input row becomes one accumulator write
  sa_delay_line #(.DEPTH(MMU_LAT), .WIDTH(1)) u_mmu_dly (
    .clk   (clk),
    .reset (reset),
    .din   (mm_en),
    .dout  (acc_we)
  );

endmodule

// File: tb/tb_sa_tile_sequencer.sv
module tb_sa_tile_sequencer;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int AW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_ub_base, cmd_wb_base, cmd_acc_base;
  logic [LW-1:0] cmd_rows;
  logic          cmd_accumulate;
  logic          busy, done, err;
  logic          wb_re, weight_fifo_en, mmu_load_weight;
  logic [AW-1:0] wb_addr, ub_addr, acc_addr;
  logic          ub_re, data_fifo_en, mm_en, acc_we, acc_en;

  always #5 clk = ~clk;

  sa_tile_sequencer #(.ARRAY_N(N), .ADDR_W(AW), .LEN_W(LW), .MMU_LAT(L)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_ub_base     (cmd_ub_base),
    .cmd_wb_base     (cmd_wb_base),
    .cmd_acc_base    (cmd_acc_base),
    .cmd_rows        (cmd_rows),
    .cmd_accumulate  (cmd_accumulate),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .wb_re           (wb_re),
    .wb_addr         (wb_addr),
    .weight_fifo_en  (weight_fifo_en),
    .mmu_load_weight (mmu_load_weight),
    .ub_re           (ub_re),
    .ub_addr         (ub_addr),
    .data_fifo_en    (data_fifo_en),
    .mm_en           (mm_en),
    .acc_we          (acc_we),
    .acc_addr        (acc_addr),
    .acc_en          (acc_en)
  );

  typedef struct packed {
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       wb_re;
    logic [7:0] wb_addr;
    logic       wfe;
    logic       mlw;
    logic       ub_re;
    logic [7:0] ub_addr;
    logic       dfe;
    logic       mm_en;
    logic       acc_we;
    logic [7:0] acc_addr;
    logic       acc_en;
  } obs_t;

  typedef struct {
    logic [7:0] ub;
    logic [7:0] wb;
    logic [7:0] acc;
    logic [7:0] rows;
    logic       accum;
    int         done_cyc;
  } vec_t;

  obs_t act;
  assign act = {cmd_ready, busy, done, err, wb_re, wb_addr, weight_fifo_en,
                mmu_load_weight, ub_re, ub_addr, data_fifo_en, mm_en,
                acc_we, acc_addr, acc_en};

  int n_chk  = 0;
  int n_pass = 0;

  // Expected outputs in cycle n after acceptance (cycle 0), from the tile timing.
  function automatic obs_t model(int n, vec_t v);
    obs_t e;
    int   r;
    e = '0;
    r = int'(v.rows);
    e.busy      = (n >= 1) && (n <= N + r + L + 4);
    e.cmd_ready = !e.busy;
    e.done      = (n == N + r + L + 4);
    if (n >= 1 && n <= N) begin
      e.wb_re   = 1'b1;
      e.wb_addr = v.wb + 8'(n - 1);
    end
    e.wfe = (n >= 2) && (n <= N + 1);
    e.mlw = (n == N + 2);
    if (n >= N + 3 && n <= N + 2 + r) begin
      e.ub_re   = 1'b1;
      e.ub_addr = v.ub + 8'(n - N - 3);
    end
    e.dfe   = (n >= N + 4) && (n <= N + 3 + r);
    e.mm_en = e.dfe;
    if (n >= N + 4 + L && n <= N + 3 + r + L) begin
      e.acc_we   = 1'b1;
      e.acc_addr = v.acc + 8'(n - N - 4 - L);
      e.acc_en   = v.accum;
    end
    return e;
  endfunction

  task automatic check(input string tag, input int n, input obs_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc %0d: got %h required %h", tag, n, act, exp);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", tag, got, exp);
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_ub_base    = v.ub;
    cmd_wb_base    = v.wb;
    cmd_acc_base   = v.acc;
    cmd_rows       = v.rows;
    cmd_accumulate = v.accum;
  endtask

  // Offer a command at a negedge; it is accepted at the following posedge.
  task automatic start_cmd(input vec_t v);
    @(negedge clk);
    drive_cmd(v);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  vec_t vecs [4];
  obs_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v, v2;
    int   done_at;

    vecs[0] = '{ub:8'h20, wb:8'h10, acc:8'h30, rows:8'd3, accum:1'b0, done_cyc:19};
    vecs[1] = '{ub:8'h20, wb:8'h10, acc:8'h30, rows:8'd1, accum:1'b1, done_cyc:17};
    vecs[2] = '{ub:8'hFE, wb:8'h10, acc:8'h30, rows:8'd4, accum:1'b0, done_cyc:20};
    vecs[3] = '{ub:8'h05, wb:8'hFD, acc:8'hFF, rows:8'd2, accum:1'b1, done_cyc:18};

    idle           = '0;
    idle.cmd_ready = 1'b1;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    drive_cmd(vecs[0]);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset state", 0, idle);

    // Full tiles, every cycle compared
    for (int k = 0; k < 4; k++) begin
      start_cmd(vecs[k]);
      done_at = -1;
      for (int n = 1; n <= vecs[k].done_cyc + 2; n++) begin
        @(negedge clk);
        if (done && done_at < 0) done_at = n;
        check($sformatf("tile%0d", k), n, model(n, vecs[k]));
      end
      check_int($sformatf("tile%0d done cycle", k), done_at, vecs[k].done_cyc);
    end

    // Zero-row command: err pulse only
    v      = vecs[0];
    v.rows = 8'd0;
    start_cmd(v);
    begin
      obs_t e;
      e     = idle;
      e.err = 1'b1;
      @(negedge clk);
      check("rows0 err", 1, e);
      for (int n = 2; n <= 8; n++) begin
        @(negedge clk);
        check("rows0 quiet", n, idle);
      end
    end

    // Reset during STREAM aborts the tile
    start_cmd(vecs[0]);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check("abort pre", n, model(n, vecs[0]));
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 10; n <= 30; n++) begin
      @(negedge clk);
      check("abort post", n, idle);
    end

    // cmd_valid held across two commands; fields changed mid-tile
    v     = vecs[1];
    v2    = v;
    v2.wb = 8'h50;
    @(negedge clk);
    drive_cmd(v);
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      check("b2b first", n, model(n, v));
      if (n == 5) cmd_wb_base = 8'h50;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      check("b2b second", n, model(n, v2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
- Parametrised tile-level sequencer for the systolic-array datapath; successor to the fixed-function instruction-driven control path.
- Accepts one matmul-tile command over a valid/ready handshake, then runs the full tile with no further commands:
  - weight-buffer reads into the weight FIFO, then the MMU weight latch;
  - unified-buffer row streaming into the data FIFO and MMU;
  - delayed accumulator writes in overwrite or accumulate mode.
- Sits between the instruction decoder and the buffers, FIFOs, MMU and accumulator; pulses done when the tile completes.

Parameters:
- ARRAY_N, 16, systolic array dimension; number of weight rows loaded per tile.
- ADDR_W, 8, buffer and accumulator address width.
- LEN_W, 8, width of the activation row-count field.
- MMU_LAT, 32, cycles from an MMU input row (mm_en) to its result on aout; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_ub_base  in  ADDR_W  first activation row address.
- cmd_wb_base  in  ADDR_W  first weight row address.
- cmd_acc_base  in  ADDR_W  first accumulator address.
- cmd_rows  in  LEN_W  activation row count R.
- cmd_accumulate  in  1  1 = add into accumulator, 0 = overwrite.
- busy  out  1  high from the cycle after acceptance through DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal command.
- wb_re, wb_addr  out  1, ADDR_W  weight buffer read.
- weight_fifo_en  out  1  weight FIFO shift.
- mmu_load_weight  out  1  MMU weight latch.
- ub_re, ub_addr  out  1, ADDR_W  unified buffer read.
- data_fifo_en  out  1  data FIFO shift.
- mm_en  out  1  MMU compute enable.
- acc_we, acc_addr  out  1, ADDR_W  accumulator write.
- acc_en  out  1  accumulate-mode qualifier; valid whenever acc_we is high.

Behaviour:
- Reset: state IDLE and all counters cleared. Every output is 0 except cmd_ready = 1. Reset in any state aborts the tile on the next edge; no done pulse and no further strobes.
- Handshake: a command is accepted when cmd_valid && cmd_ready at a rising edge (call this cycle 0). All command fields and the mode bit are latched at that edge.
- cmd_rows == 0: the command is still accepted. err pulses in cycle 1, state stays IDLE, and no strobes or busy are produced.
- States: IDLE -> WLOAD -> WLATCH -> STREAM -> DRAIN -> DONE -> IDLE.
- WLOAD, cycles 1..ARRAY_N: wb_re = 1, wb_addr = wb_base + k for k = 0..ARRAY_N-1. weight_fifo_en is wb_re delayed one cycle (BRAM read latency), i.e. high in cycles 2..ARRAY_N+1.
- WLATCH, cycle ARRAY_N+2: mmu_load_weight = 1 for exactly one cycle.
- STREAM, R cycles starting at ARRAY_N+3: ub_re = 1, ub_addr = ub_base + i for i = 0..R-1.
- Data path: data_fifo_en and mm_en are ub_re delayed one cycle.
- Accumulator writes: acc_we is mm_en delayed MMU_LAT cycles, implemented as a valid shift register. acc_addr = acc_base + j, where j increments after each write. acc_en = latched mode.
- DRAIN: entered after the last ub_re. Exits when the valid pipeline is empty and the last acc_we has been issued.
- DONE: one cycle with done = 1, then IDLE, where cmd_ready = 1.
- Done timing: done fires in cycle ARRAY_N + R + MMU_LAT + 4.
- Back-to-back commands: the earliest next acceptance is the cycle after done.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent and legal.
- cmd_valid outside IDLE is ignored.

Decomposition:
- Shared package sa_pkg holds:
  - state encoding (IDLE..DONE);
  - the default ARRAY_N, ADDR_W and MMU_LAT constants;
  - the command field layout, shared with the instruction decoder.
- One natural sub-module, sa_delay_line (parametrised depth and width valid shift register). It is used for the 1-cycle BRAM delays and the MMU_LAT result delay.

Test Plan:
- ARRAY_N=4, MMU_LAT=8, wb_base=0x10, ub_base=0x20, acc_base=0x30, R=3, accumulate=0, accept at cycle 0 -> expected:
  - wb_re in cycles 1-4 with addresses 0x10-0x13;
  - weight_fifo_en in cycles 2-5;
  - mmu_load_weight in cycle 6;
  - ub_re in cycles 7-9 with addresses 0x20-0x22;
  - mm_en in cycles 8-10;
  - acc_we in cycles 16-18 with addresses 0x30-0x32 and acc_en = 0;
  - done in cycle 19.
- Same command with accumulate=1 and R=1 -> one acc_we at acc_addr 0x30 with acc_en = 1; done in cycle 17.
- Wrap: ub_base=0xFE, R=4 -> ub_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- cmd_rows=0 -> err pulse in cycle 1; busy, strobes and done stay 0; cmd_ready stays 1.
- reset asserted in cycle 9 (during STREAM) -> from the next edge all strobes and busy are 0, cmd_ready = 1, and no done ever fires.
- cmd_valid held high across two commands -> the second is accepted in the cycle after done; cmd_valid during busy has no effect.
